// File: rtl/lm_sm_sequencer_pkg.sv
// Shared types and constants for the LM/SM (load/store multiple) sequencer.
package lm_sm_sequencer_pkg;

  localparam int DATA_W    = 16;
  localparam int NREG      = 8;
  localparam int REG_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : lm_sm_sequencer_pkg

// File: rtl/lm_sm_sequencer_lsb_prio_enc.sv
// Lowest-index-first priority encoder: R0 wins over every higher register.
module lsb_prio_enc
  import lm_sm_sequencer_pkg::*;
#(
  parameter int NREG = lm_sm_sequencer_pkg::NREG
) (
  input  logic [NREG-1:0]      i_list,
  output logic [REG_IDX_W-1:0] o_idx,
  output logic                 o_valid
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_valid = |i_list;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_list[i]) o_idx = REG_IDX_W'(i);
    end
  end

endmodule : lsb_prio_enc

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks a latched register list one register per cycle,
// streaming registers to memory (SM) or memory into registers (LM).
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int DATA_W = lm_sm_sequencer_pkg::DATA_W,
  parameter int NREG   = lm_sm_sequencer_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_sm,
  input  logic [NREG-1:0]      reg_list,
  input  logic [DATA_W-1:0]    base_addr,
  input  logic [DATA_W-1:0]    rf_rdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_write_n,
  output logic [REG_IDX_W-1:0] rf_raddr,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 stall,
  output logic                 done
);

  state_e                r_state;
  logic [NREG-1:0]       r_list;
  logic [DATA_W-1:0]     r_addr;
  logic                  r_is_sm;

  logic [REG_IDX_W-1:0]  w_idx;
  logic                  w_valid;
  logic [NREG-1:0]       w_list_next;
  logic                  w_xfer;

  lsb_prio_enc #(.NREG(NREG)) u_prio_enc (
    .i_list  (r_list),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Clearing the lowest set bit is exactly the bit the encoder selected.
  assign w_list_next = r_list & (r_list - NREG'(1));
  assign w_xfer      = (r_state == XFER) && w_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_list  <= '0;
      r_addr  <= '0;
      r_is_sm <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_list  <= reg_list;
            r_addr  <= base_addr;
            r_is_sm <= is_sm;
            r_state <= (reg_list != '0) ? XFER : DONE;
          end
        end
        XFER: begin
          r_list <= w_list_next;
          r_addr <= r_addr + DATA_W'(1);
          if (w_list_next == '0) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes and buses decode only registered state; start never reaches them.
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_write_n = 1'b1;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    if (w_xfer) begin
      mem_addr = r_addr;
      if (r_is_sm) begin
        rf_raddr    = w_idx;
        mem_wdata   = rf_rdata;
        mem_write_n = 1'b0;
      end else begin
        rf_waddr = w_idx;
        rf_wdata = mem_rdata;
        rf_we    = 1'b1;
      end
    end
  end

  assign stall = (r_state == XFER);
  assign done  = (r_state == DONE);

endmodule : lm_sm_sequencer

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: directed ops push expected transfers,
// a negedge monitor pops and compares every strobe the DUT presents.
module tb_lm_sm_sequencer;

  typedef enum logic [1:0] {EV_MEM, EV_RF, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_sm;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic [15:0] rf_rdata;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write_n;
  logic [2:0]  rf_raddr;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        stall;
  logic        done;

  logic [15:0] rf_model  [8];
  logic [15:0] mem_model [65536];

  ev_t exp_q[$];
  int  vectors      = 0;
  int  miscompares  = 0;
  int  stall_cycles = 0;

  lm_sm_sequencer #(.DATA_W(16), .NREG(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_sm       (is_sm),
    .reg_list    (reg_list),
    .base_addr   (base_addr),
    .rf_rdata    (rf_rdata),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write_n (mem_write_n),
    .rf_raddr    (rf_raddr),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .stall       (stall),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file and data memory the sequencer talks to.
  assign rf_rdata  = rf_model[rf_raddr];
  assign mem_rdata = mem_model[mem_addr];

  always @(posedge clk) begin
    if (reset && !mem_write_n) mem_model[mem_addr] <= mem_wdata;
    if (reset && rf_we)        rf_model[rf_waddr]  <= rf_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_e kind, input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input ev_kind_e kind, input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_%s: got addr=%h data=%h, expected no event (t=%0t)",
               kind.name(), addr, data, $time);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", 32'(kind), 32'(e.kind));
    check("ev_addr", {16'h0, addr}, {16'h0, e.addr});
    check("ev_data", {16'h0, data}, {16'h0, e.data});
  endtask

  // Monitor: samples mid-cycle, far from the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      if (stall)        stall_cycles++;
      if (!mem_write_n) check_event(EV_MEM, mem_addr, mem_wdata);
      if (rf_we)        check_event(EV_RF, {13'h0, rf_waddr}, rf_wdata);
      if (done)         check_event(EV_DONE, 16'h0, 16'h0);
    end
  end

  task automatic start_op(input logic sm, input logic [7:0] list, input logic [15:0] base);
    @(posedge clk); #1;
    stall_cycles = 0;
    start     = 1'b1;
    is_sm     = sm;
    reg_list  = list;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts negedges from here until done; the bound turns a hang into a FAIL.
  task automatic wait_done(input string name, input int exp_cycles, input int exp_stall);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    #1;
    check({name, "_done_cycles"}, 32'(n), 32'(exp_cycles));
    check({name, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_mem_write_n"}, {31'h0, mem_write_n}, 32'h1);
    check({name, "_rf_we"},       {31'h0, rf_we},       32'h0);
    check({name, "_stall"},       {31'h0, stall},       32'h0);
    check({name, "_done"},        {31'h0, done},        32'h0);
    check({name, "_mem_addr"},    {16'h0, mem_addr},    32'h0);
    check({name, "_mem_wdata"},   {16'h0, mem_wdata},   32'h0);
    check({name, "_rf_idx"},      {26'h0, rf_raddr, 3'h0} | {29'h0, rf_waddr}, 32'h0);
    check({name, "_rf_wdata"},    {16'h0, rf_wdata},    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rf_model[0] = 16'h1111; rf_model[1] = 16'hA1A1;
    rf_model[2] = 16'h2222; rf_model[3] = 16'h3333;
    rf_model[4] = 16'h4444; rf_model[5] = 16'h5555;
    rf_model[6] = 16'h6666; rf_model[7] = 16'h7777;
    mem_model[16'h0017] = 16'h0010;
    mem_model[16'h0018] = 16'h0005;
    mem_model[16'h0050] = 16'hBEEF;
    mem_model[16'h0051] = 16'hCAFE;

    reset = 1'b0; start = 1'b0; is_sm = 1'b0; reg_list = '0; base_addr = '0;
    #3;
    check_idle_outputs("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // SM 0x05 @0x0014: R0, R2, then done.
    push(EV_MEM, 16'h0014, 16'h1111);
    push(EV_MEM, 16'h0015, 16'h2222);
    push(EV_DONE, 16'h0, 16'h0);
    start_op(1'b1, 8'h05, 16'h0014);
    wait_done("sm05", 3, 2);

    // SM 0xFF @0xFFFE: address wraps past 0xFFFF.
    push(EV_MEM, 16'hFFFE, 16'h1111);
    push(EV_MEM, 16'hFFFF, 16'hA1A1);
    push(EV_MEM, 16'h0000, 16'h2222);
    push(EV_MEM, 16'h0001, 16'h3333);
    push(EV_MEM, 16'h0002, 16'h4444);
    push(EV_MEM, 16'h0003, 16'h5555);
    push(EV_MEM, 16'h0004, 16'h6666);
    push(EV_MEM, 16'h0005, 16'h7777);
    push(EV_DONE, 16'h0, 16'h0);
    start_op(1'b1, 8'hFF, 16'hFFFE);
    wait_done("smff", 9, 8);

    // SM 0x81 with a second start during XFER and another during DONE, both ignored.
    push(EV_MEM, 16'h0100, 16'h1111);
    push(EV_MEM, 16'h0101, 16'h7777);
    push(EV_DONE, 16'h0, 16'h0);
    start_op(1'b1, 8'h81, 16'h0100);
    start = 1'b1; is_sm = 1'b0; reg_list = 8'h02; base_addr = 16'h0200;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("sm81", 2, 2);
    start = 1'b1; is_sm = 1'b1; reg_list = 8'h01; base_addr = 16'h0300;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("sm81_idle_stall", {31'h0, stall}, 32'h0);

    // LM 0x0C @0x0017: R2 <- 0x0010, R3 <- 0x0005, no memory writes.
    push(EV_RF, 16'h0002, 16'h0010);
    push(EV_RF, 16'h0003, 16'h0005);
    push(EV_DONE, 16'h0, 16'h0);
    start_op(1'b0, 8'h0C, 16'h0017);
    wait_done("lm0c", 3, 2);
    @(negedge clk); #1;
    check("lm0c_r2", {16'h0, rf_model[2]}, 32'h0010);
    check("lm0c_r3", {16'h0, rf_model[3]}, 32'h0005);

    // LM with empty list: done right after start, never stalls.
    push(EV_DONE, 16'h0, 16'h0);
    start_op(1'b0, 8'h00, 16'h0040);
    wait_done("lm00", 1, 0);

    // SM 0x0E aborted by reset after its first transfer.
    push(EV_MEM, 16'h0030, 16'hA1A1);
    start_op(1'b1, 8'h0E, 16'h0030);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    check("abort_queue_drained", 32'(exp_q.size()), 32'h0);

    // Fresh LM 0x90 @0x0050 after reset release.
    push(EV_RF, 16'h0004, 16'hBEEF);
    push(EV_RF, 16'h0007, 16'hCAFE);
    push(EV_DONE, 16'h0, 16'h0);
    start_op(1'b0, 8'h90, 16'h0050);
    wait_done("lm90", 3, 2);
    repeat (3) @(negedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_lm_sm_sequencer

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 Parameter: DATA_W, 16, width of data words and memory addresses.
REQ-002 Parameter: NREG, 8, number of architectural registers; the register-list width.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle request to begin an LM/SM operation.
REQ-007 is_sm  in  1  1 = store multiple, 0 = load multiple; sampled with start.
REQ-008 reg_list  in  NREG  bit i set = transfer Ri; sampled with start.
REQ-009 base_addr  in  DATA_W  first memory address; sampled with start.
REQ-010 rf_rdata  in  DATA_W  register-file read data for rf_raddr, combinational.
REQ-011 mem_rdata  in  DATA_W  data-memory read data for mem_addr, combinational.
REQ-012 mem_addr  out  DATA_W  data-memory read and write address.
REQ-013 mem_wdata  out  DATA_W  data-memory write data.
REQ-014 mem_write_n  out  1  data-memory write enable, active-low.
REQ-015 rf_raddr  out  3  register-file read index (SM source).
REQ-016 rf_we  out  1  register-file write enable, active-high (LM).
REQ-017 rf_waddr  out  3  register-file write index.
REQ-018 rf_wdata  out  DATA_W  register-file write data.
REQ-019 stall  out  1  holds upstream pipeline stages while transfers remain.
REQ-020 done  out  1  one-cycle completion pulse.

Function
REQ-021 States: IDLE, XFER, DONE; only IDLE accepts start.
REQ-022 IDLE + start: latch reg_list, base_addr and is_sm; go to XFER if reg_list != 0, else go to DONE.
REQ-023 Each XFER cycle transfers exactly one register: the lowest set bit i of the pending list.
REQ-024 XFER, SM: mem_addr = current address; rf_raddr = i; mem_wdata = rf_rdata; mem_write_n = 0.
REQ-025 XFER, LM: mem_addr = current address; rf_waddr = i; rf_wdata = mem_rdata; rf_we = 1; mem_write_n = 1.
REQ-026 After each transfer: clear bit i; current address += 1, modulo 2^DATA_W (0xFFFF wraps to 0x0000).
REQ-027 XFER with exactly one pending bit: perform that transfer, then go to DONE.
REQ-028 DONE: assert done for one cycle, then go to IDLE; a start in DONE is ignored.
REQ-029 stall = 1 exactly while state is XFER.
REQ-030 A start in XFER is ignored and leaves latched state unchanged.
REQ-031 Outside XFER: mem_write_n = 1 and rf_we = 0; no side effects.
REQ-032 Latency: first transfer occurs in the cycle after start; N set bits take N XFER cycles plus 1 DONE cycle.
REQ-033 All strobes (mem_write_n, rf_we, done) are decoded from registered state; no combinational path from start to any strobe.

Reset
REQ-034 reset = 0 forces: state IDLE; latched list 0; address 0; mem_write_n = 1; rf_we = 0; stall = 0; done = 0; all address and data outputs 0.
REQ-035 Reset during XFER aborts the operation immediately, with no further memory or register writes.
REQ-036 Operation resumes on the first rising clk edge after reset returns to 1.

Structure
REQ-037 A shared package holds the state enum (IDLE, XFER, DONE), DATA_W, NREG and the REG_IDX_W = 3 constant.
REQ-038 One sub-module, lsb_prio_enc, maps the pending NREG-bit list to a 3-bit index plus a valid flag.
REQ-039 Lowest-index priority: bit 0 = R0 has the highest priority.

Verification
REQ-040 SM, list 0x05, base 0x0014, R0 = 0x1111, R2 = 0x2222 -> cycle 1: write 0x1111 @0x0014; cycle 2: write 0x2222 @0x0015; cycle 3: done; stall high for 2 cycles.
REQ-041 LM, list 0x0C, base 0x0017, mem[0x17] = 0x0010, mem[0x18] = 0x0005 -> R2 = 0x0010 then R3 = 0x0005; mem_write_n stays 1 throughout.
REQ-042 LM, list 0x00 -> stall never asserted; done pulses in the cycle after start; no writes.
REQ-043 SM, list 0xFF, base 0xFFFE -> 8 writes at addresses 0xFFFE, 0xFFFF, 0x0000 ... 0x0005; done on the 9th cycle.
REQ-044 Second start asserted during XFER of list 0x81 -> ignored; exactly 2 transfers occur (R0, then R7).
REQ-045 Reset asserted after the 1st of 3 transfers -> outputs immediately at reset values, no further writes; a fresh start after release behaves normally.
